// File: rtl/cart_mbc1_responder.sv
// ---------------------------------------------------------------------------
// cart_mbc1_responder
//
// Cartridge-side responder for the external CPU bus. Samples the asynchronous
// bus pins on a fast local clock, decodes read/write strobes with a small
// IDLE/READ/WRITE state machine, and implements the MBC1 banking registers
// (RAM enable, 5-bit low bank, 2-bit high bank, banking mode).
//
// Ports
//   clk        oversampling clock (>= 8x bus T-cycle rate)
//   nreset     asynchronous active-low reset
//   a          cartridge address pins
//   d_in       data pins as seen by the cartridge
//   d_out      data the cartridge drives onto the pins
//   d_oe       1 = cartridge drives D
//   nrd        /RD pin, active-low
//   nwr        /WR pin, active-low
//   ncs        /CS pin, active-low (A000-BFFF window)
//   rom_addr   byte address into the ROM image (registered every cycle)
//   rom_data   ROM image data for rom_addr (combinational)
//   ram_addr   byte address into cart RAM (registered every cycle)
//   ram_data   cart RAM read data (combinational)
//   ram_wdata  cart RAM write data
//   ram_we     one-cycle cart RAM write pulse
// ---------------------------------------------------------------------------
module cart_mbc1_responder #(
  parameter int ROM_BANK_BITS = 6,
  parameter int RAM_BANK_BITS = 2,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic [15:0]                   a,
  input  logic [7:0]                    d_in,
  output logic [7:0]                    d_out,
  output logic                          d_oe,
  input  logic                          nrd,
  input  logic                          nwr,
  input  logic                          ncs,
  output logic [14+ROM_BANK_BITS-1:0]   rom_addr,
  input  logic [7:0]                    rom_data,
  output logic [13+RAM_BANK_BITS-1:0]   ram_addr,
  input  logic [7:0]                    ram_data,
  output logic [7:0]                    ram_wdata,
  output logic                          ram_we
);

  localparam int ROM_AW = 14 + ROM_BANK_BITS;
  localparam int RAM_AW = 13 + RAM_BANK_BITS;

  // Synchroniser word layout: {a[15:0], d_in[7:0], ncs, nwr, nrd}
  localparam int                PINS_W    = 27;
  localparam logic [PINS_W-1:0] PINS_IDLE = {16'h0000, 8'h00, 3'b111};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE
  } state_t;

  // -------------------------------------------------------------------------
  // Pin synchroniser
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][PINS_W-1:0] r_sync;

  // NOTE: the synchroniser chain is reset to the idle pin state (strobes
  // high) so no phantom strobe reaches the FSM as nreset releases.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_sync <= {SYNC_STAGES{PINS_IDLE}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], a, d_in, ncs, nwr, nrd};
    end
  end

  logic [PINS_W-1:0] w_s;
  logic [15:0]       w_s_a;
  logic [7:0]        w_s_d;
  logic              w_s_ncs;
  logic              w_s_nwr;
  logic              w_s_nrd;

  assign w_s     = r_sync[SYNC_STAGES-1];
  assign w_s_a   = w_s[26:11];
  assign w_s_d   = w_s[10:3];
  assign w_s_ncs = w_s[2];
  assign w_s_nwr = w_s[1];
  assign w_s_nrd = w_s[0];

  // -------------------------------------------------------------------------
  // Banking registers, captured write, FSM state
  // -------------------------------------------------------------------------
  state_t      r_state;
  logic        r_ram_en;
  logic [4:0]  r_bank_lo;
  logic [1:0]  r_bank_hi;
  logic        r_mode;
  logic [15:0] r_cap_a;
  logic [7:0]  r_cap_d;
  logic        r_cap_ncs;

  // -------------------------------------------------------------------------
  // Read selection and bank mapping from the synchronised address
  // -------------------------------------------------------------------------
  logic        w_rom_sel;
  logic        w_ram_sel;
  logic        w_rd_sel;
  logic [6:0]  w_rom_bank;
  logic [1:0]  w_ram_bank;
  logic [20:0] w_rom_full;
  logic [14:0] w_ram_live;
  logic [14:0] w_ram_commit;
  logic        w_commit;

  assign w_rom_sel = !w_s_a[15];
  assign w_ram_sel = (w_s_a[15:13] == 3'b101) && !w_s_ncs && r_ram_en;
  assign w_rd_sel  = w_rom_sel || w_ram_sel;

  // 0000-3FFF sees bank 0, or the high bits alone in mode 1;
  // 4000-7FFF sees the full {bank_hi, bank_lo}.
  assign w_rom_bank = w_s_a[14] ? {r_bank_hi, r_bank_lo}
                                : (r_mode ? {r_bank_hi, 5'b00000} : 7'd0);
  assign w_ram_bank = r_mode ? r_bank_hi : 2'd0;

  // Full-width addresses; the size casts below drop bank bits beyond the
  // configured bank count, which is the masking MBC1 applies.
  assign w_rom_full   = {w_rom_bank, w_s_a[13:0]};
  assign w_ram_live   = {w_ram_bank, w_s_a[12:0]};
  assign w_ram_commit = {w_ram_bank, r_cap_a[12:0]};

  // The write is committed on the first cycle s_nwr is seen high again.
  assign w_commit = (r_state == ST_WRITE) && w_s_nwr;

  // -------------------------------------------------------------------------
  // FSM, banking registers and registered outputs
  // -------------------------------------------------------------------------
  // NOTE: non-blocking assignments throughout; a later assignment in the same
  // cycle (e.g. ram_addr in the commit branch) overrides the default above it.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state   <= ST_IDLE;
      r_ram_en  <= 1'b0;
      r_bank_lo <= 5'd1;
      r_bank_hi <= 2'd0;
      r_mode    <= 1'b0;
      r_cap_a   <= 16'h0000;
      r_cap_d   <= 8'h00;
      r_cap_ncs <= 1'b1;
      d_oe      <= 1'b0;
      d_out     <= 8'h00;
      ram_we    <= 1'b0;
      ram_wdata <= 8'h00;
      rom_addr  <= '0;
      ram_addr  <= '0;
    end else begin
      ram_we   <= 1'b0;
      rom_addr <= ROM_AW'(w_rom_full);
      ram_addr <= RAM_AW'(w_ram_live);

      // Track the bus while /WR is low so the commit uses the final values.
      if (!w_s_nwr) begin
        r_cap_a   <= w_s_a;
        r_cap_d   <= w_s_d;
        r_cap_ncs <= w_s_ncs;
      end

      case (r_state)
        ST_IDLE: begin
          // Write wins when both strobes are low.
          if (!w_s_nwr) begin
            r_state <= ST_WRITE;
          end else if (!w_s_nrd && w_rd_sel) begin
            r_state <= ST_READ;
            d_oe    <= 1'b1;
            d_out   <= w_rom_sel ? rom_data : ram_data;
          end
        end

        ST_READ: begin
          if (!w_s_nwr) begin
            r_state <= ST_WRITE;
            d_oe    <= 1'b0;
          end else if (w_s_nrd) begin
            r_state <= ST_IDLE;
            d_oe    <= 1'b0;
          end else begin
            d_out <= w_rom_sel ? rom_data : ram_data;
          end
        end

        ST_WRITE: begin
          if (w_commit) begin
            r_state <= ST_IDLE;
            case (r_cap_a[15:13])
              3'b000: r_ram_en  <= (r_cap_d[3:0] == 4'hA);
              // MBC1 quirk: a zero low bank field selects bank 1.
              3'b001: r_bank_lo <= (r_cap_d[4:0] == 5'd0) ? 5'd1 : r_cap_d[4:0];
              3'b010: r_bank_hi <= r_cap_d[1:0];
              3'b011: r_mode    <= r_cap_d[0];
              3'b101: begin
                if (!r_cap_ncs && r_ram_en) begin
                  ram_we    <= 1'b1;
                  ram_wdata <= r_cap_d;
                  ram_addr  <= RAM_AW'(w_ram_commit);
                end
              end
              default: ;
            endcase
          end
        end

        default: begin
          r_state <= ST_IDLE;
          d_oe    <= 1'b0;
        end
      endcase
    end
  end

endmodule
